// File: rtl/uart_rx_top.sv
// UART receiver: 2-FF synchroniser, 16x oversampling deframer and a DEPTH-entry byte FIFO.
// Define UART_RX_PARITY_EN for 8E1 framing with a parity_error pulse; the default build is 8N1.
module uart_rx_top #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 19200,
    parameter int DEPTH     = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_pin,
    input  logic       read_enable,
    output logic [7:0] dout,
    output logic       rx_valid,
    output logic       fifo_empty,
    output logic       fifo_full,
    output logic       frame_error,
    output logic       overrun,
`ifdef UART_RX_PARITY_EN
    output logic       parity_error,
`endif
    output logic       rx_busy
);

    localparam int DIV   = CLK_FREQ / (BAUD_RATE * 16);
    localparam int DIV_W = $clog2(DIV + 1);
    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = PW + 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_IDLE
    } state_e;

    function automatic logic even_parity(input logic [7:0] data);
        even_parity = ^data;
    endfunction

    logic             rx_meta_q;
    logic             rx_s_q;
    logic [DIV_W-1:0] div_q;
    logic             tick_s;
    logic             start_det_s;
    state_e           state_q;
    logic [3:0]       samp_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shift_q;
    logic             push_q;
    logic [7:0]       push_data_q;
    logic             frame_error_q;
    logic             busy_q;
`ifdef UART_RX_PARITY_EN
    logic             parity_error_q;
    logic             par_bad_q;
`endif
    logic [7:0]       mem [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             pop_s;
    logic             wr_s;
    logic             ovr_s;
    logic [7:0]       dout_q;
    logic             rx_valid_q;
    logic             empty_q;
    logic             full_q;
    logic             overrun_q;

    // Two-stage synchroniser for the asynchronous line, idling high.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx_pin;
            rx_s_q    <= rx_meta_q;
        end
    end

    assign tick_s      = (div_q == DIV_W'(DIV - 1));
    assign start_det_s = (state_q == IDLE) && !rx_s_q;

    // Oversample tick divider, re-phased on each start edge so ticks align to the frame.
    always_ff @(posedge clk) begin
        if (!rst || start_det_s) begin
            div_q <= '0;
        end else if (tick_s) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + DIV_W'(1);
        end
    end

    // Deframing FSM: start-bit validation at mid-bit, then one sample per 16 ticks.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= IDLE;
            samp_q        <= 4'd0;
            bit_idx_q     <= 3'd0;
            shift_q       <= 8'h00;
            push_q        <= 1'b0;
            push_data_q   <= 8'h00;
            frame_error_q <= 1'b0;
            busy_q        <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_error_q <= 1'b0;
            par_bad_q      <= 1'b0;
`endif
        end else begin
            push_q        <= 1'b0;
            frame_error_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_error_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (!rx_s_q) begin
                        state_q <= START;
                        samp_q  <= 4'd0;
                        busy_q  <= 1'b1;
`ifdef UART_RX_PARITY_EN
                        par_bad_q <= 1'b0;
`endif
                    end
                end
                START: begin
                    if (tick_s) begin
                        if (samp_q == 4'd7) begin
                            if (!rx_s_q) begin
                                state_q   <= DATA;
                                samp_q    <= 4'd0;
                                bit_idx_q <= 3'd0;
                            end else begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                            end
                        end else begin
                            samp_q <= samp_q + 4'd1;
                        end
                    end
                end
                DATA: begin
                    if (tick_s) begin
                        samp_q <= samp_q + 4'd1;
                        if (samp_q == 4'd15) begin
                            shift_q[bit_idx_q] <= rx_s_q;
                            bit_idx_q          <= bit_idx_q + 3'd1;
                            if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                                state_q <= PARITY;
`else
                                state_q <= STOP;
`endif
                            end
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (tick_s) begin
                        samp_q <= samp_q + 4'd1;
                        if (samp_q == 4'd15) begin
                            state_q <= STOP;
                            if (rx_s_q != even_parity(shift_q)) begin
                                parity_error_q <= 1'b1;
                                par_bad_q      <= 1'b1;
                            end
                        end
                    end
                end
`endif
                STOP: begin
                    if (tick_s) begin
                        samp_q <= samp_q + 4'd1;
                        if (samp_q == 4'd15) begin
                            if (rx_s_q) begin
`ifdef UART_RX_PARITY_EN
                                push_q <= !par_bad_q;
`else
                                push_q <= 1'b1;
`endif
                                push_data_q <= shift_q;
                                state_q     <= IDLE;
                                busy_q      <= 1'b0;
                            end else begin
                                frame_error_q <= 1'b1;
                                state_q       <= WAIT_IDLE;
                            end
                        end
                    end
                end
                WAIT_IDLE: begin
                    if (tick_s && rx_s_q) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign pop_s = read_enable && !empty_q;
    assign wr_s  = push_q && (!full_q || pop_s);
    assign ovr_s = push_q && full_q && !pop_s;

    // Occupancy after this cycle's push/pop; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_d = count_q;
        case ({wr_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage array; no reset needed since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (wr_s) begin
            mem[wr_ptr_q] <= push_data_q;
        end
    end

    // FIFO pointers, status flags and pop-side registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            dout_q     <= 8'h00;
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            if (wr_s) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop_s) begin
                dout_q   <= mem[rd_ptr_q];
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            rx_valid_q <= pop_s;
            overrun_q  <= ovr_s;
            count_q    <= count_d;
            empty_q    <= (count_d == CW'(0));
            full_q     <= (count_d == CW'(DEPTH));
        end
    end

    assign dout        = dout_q;
    assign rx_valid    = rx_valid_q;
    assign fifo_empty  = empty_q;
    assign fifo_full   = full_q;
    assign frame_error = frame_error_q;
    assign overrun     = overrun_q;
    assign rx_busy     = busy_q;
`ifdef UART_RX_PARITY_EN
    assign parity_error = parity_error_q;
`endif

endmodule

// File: tb/tb_uart_rx_top.sv
// Directed bench for uart_rx_top at DIV=10 (160 clocks per bit), default 8N1 build.
module tb_uart_rx_top;

    localparam int BIT_CLKS = 160;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_pin;
    logic       read_enable;
    logic [7:0] dout;
    logic       rx_valid;
    logic       fifo_empty;
    logic       fifo_full;
    logic       frame_error;
    logic       overrun;
    logic       rx_busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_error;
`endif

    int n_total = 0;
    int n_bad   = 0;
    int fe_cnt  = 0;
    int ov_cnt  = 0;
    int rv_cnt  = 0;
    int fe0, ov0, rv0;

    uart_rx_top #(
        .CLK_FREQ (1_600_000),
        .BAUD_RATE(10_000),
        .DEPTH    (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_pin      (rx_pin),
        .read_enable (read_enable),
        .dout        (dout),
        .rx_valid    (rx_valid),
        .fifo_empty  (fifo_empty),
        .fifo_full   (fifo_full),
        .frame_error (frame_error),
        .overrun     (overrun),
`ifdef UART_RX_PARITY_EN
        .parity_error(parity_error),
`endif
        .rx_busy     (rx_busy)
    );

    always #5 clk = ~clk;

    // Count single-cycle pulses away from the active edge.
    always @(negedge clk) begin
        if (frame_error) fe_cnt++;
        if (overrun)     ov_cnt++;
        if (rx_valid)    rv_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one frame; entered and left #1 after a rising edge.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rx_pin = 1'b0;
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            rx_pin = b[i];
            wait_clks(BIT_CLKS);
        end
        rx_pin = stop_bit;
        wait_clks(BIT_CLKS);
    endtask

    task automatic read_check(input string tag, input logic [7:0] exp);
        read_enable = 1'b1;
        wait_clks(1);
        read_enable = 1'b0;
        check_eq({tag, "_valid"}, {31'd0, rx_valid}, 32'd1);
        check_eq({tag, "_dout"}, {24'd0, dout}, {24'd0, exp});
    endtask

    initial begin
        rst         = 1'b0;
        rx_pin      = 1'b1;
        read_enable = 1'b0;
        wait_clks(3);
        check_eq("rst_dout",  {24'd0, dout},        32'h0);
        check_eq("rst_valid", {31'd0, rx_valid},    32'd0);
        check_eq("rst_empty", {31'd0, fifo_empty},  32'd1);
        check_eq("rst_full",  {31'd0, fifo_full},   32'd0);
        check_eq("rst_fe",    {31'd0, frame_error}, 32'd0);
        check_eq("rst_ov",    {31'd0, overrun},     32'd0);
        check_eq("rst_busy",  {31'd0, rx_busy},     32'd0);
        rst = 1'b1;
        wait_clks(5);

        // 1: single byte, pop, then pop on empty
        rv0 = rv_cnt;
        send_frame(8'hA5, 1'b1);
        wait_clks(2 * BIT_CLKS);
        check_eq("t1_nonempty", {31'd0, fifo_empty}, 32'd0);
        read_check("t1_rd", 8'hA5);
        check_eq("t1_empty", {31'd0, fifo_empty}, 32'd1);
        read_enable = 1'b1;
        wait_clks(1);
        read_enable = 1'b0;
        check_eq("t1_empty_rd_valid", {31'd0, rx_valid}, 32'd0);
        check_eq("t1_empty_rd_dout", {24'd0, dout}, 32'hA5);
        wait_clks(2);
        check_eq("t1_valid_pulses", rv_cnt - rv0, 32'd1);

        // 2: start-bit glitch
        fe0 = fe_cnt;
        rx_pin = 1'b0;
        wait_clks(20);
        check_eq("t2_busy", {31'd0, rx_busy}, 32'd1);
        wait_clks(20);
        rx_pin = 1'b1;
        wait_clks(200);
        check_eq("t2_idle", {31'd0, rx_busy}, 32'd0);
        check_eq("t2_empty", {31'd0, fifo_empty}, 32'd1);
        check_eq("t2_no_fe", fe_cnt - fe0, 32'd0);

        // 3: framing error and stuck-low line
        fe0 = fe_cnt;
        send_frame(8'h3C, 1'b0);
        check_eq("t3_fe_pulse", fe_cnt - fe0, 32'd1);
        check_eq("t3_empty", {31'd0, fifo_empty}, 32'd1);
        wait_clks(3 * BIT_CLKS);
        check_eq("t3_wait_busy", {31'd0, rx_busy}, 32'd1);
        rx_pin = 1'b1;
        wait_clks(40);
        check_eq("t3_released", {31'd0, rx_busy}, 32'd0);
        check_eq("t3_fe_once", fe_cnt - fe0, 32'd1);
        check_eq("t3_still_empty", {31'd0, fifo_empty}, 32'd1);

        // 4: fill to full, overrun on the 17th byte, drain in order
        ov0 = ov_cnt;
        for (int i = 0; i < 17; i++) begin
            send_frame(8'(i), 1'b1);
            if (i == 14) check_eq("t4_not_full15", {31'd0, fifo_full}, 32'd0);
            if (i == 15) begin
                check_eq("t4_full16", {31'd0, fifo_full}, 32'd1);
                check_eq("t4_no_ov16", ov_cnt - ov0, 32'd0);
            end
        end
        check_eq("t4_ov_pulse", ov_cnt - ov0, 32'd1);
        check_eq("t4_full17", {31'd0, fifo_full}, 32'd1);
        for (int i = 0; i < 16; i++) begin
            read_check($sformatf("t4_rd%0d", i), 8'(i));
        end
        check_eq("t4_drained", {31'd0, fifo_empty}, 32'd1);

        // 5: pop coincident with a push into a full FIFO
        for (int i = 0; i < 16; i++) begin
            send_frame(8'(8'h20 + i), 1'b1);
        end
        check_eq("t5_full", {31'd0, fifo_full}, 32'd1);
        ov0 = ov_cnt;
        fork
            send_frame(8'h55, 1'b1);
            begin
                repeat (1523) @(posedge clk);
                #1 read_enable = 1'b1;
                wait_clks(1);
                read_enable = 1'b0;
                check_eq("t5_pop_valid", {31'd0, rx_valid}, 32'd1);
                check_eq("t5_pop_dout", {24'd0, dout}, 32'h20);
            end
        join
        check_eq("t5_no_ov", ov_cnt - ov0, 32'd0);
        check_eq("t5_still_full", {31'd0, fifo_full}, 32'd1);
        for (int i = 1; i < 16; i++) begin
            read_check($sformatf("t5_rd%0d", i), 8'(8'h20 + i));
        end
        read_check("t5_last", 8'h55);
        check_eq("t5_drained", {31'd0, fifo_empty}, 32'd1);

        // 6: reset in the middle of a frame
        fork
            send_frame(8'hFF, 1'b1);
            begin
                wait_clks(500);
                rst = 1'b0;
                wait_clks(3);
                check_eq("t6_rst_busy", {31'd0, rx_busy}, 32'd0);
                check_eq("t6_rst_dout", {24'd0, dout}, 32'h0);
                check_eq("t6_rst_empty", {31'd0, fifo_empty}, 32'd1);
                rst = 1'b1;
            end
        join
        check_eq("t6_no_partial", {31'd0, fifo_empty}, 32'd1);
        send_frame(8'h81, 1'b1);
        wait_clks(10);
        read_check("t6_rd", 8'h81);
        check_eq("t6_empty", {31'd0, fifo_empty}, 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
